// File: rtl/sub_bytes_seq.sv
// Iterative AES SubBytes/InvSubBytes: BYTES_PER_CYCLE algebraic S-box lanes
// sweep a 128-bit work register, then hold the result under valid/ready.
module sub_bytes_seq #(
    parameter int unsigned BYTES_PER_CYCLE = 4
) (
    input  logic         i_Clk,
    input  logic         i_Rst_n,
    input  logic         i_Valid,
    output logic         o_Ready,
    input  logic [127:0] i_Data,
    input  logic         i_fEncrypt,
    output logic         o_Valid,
    input  logic         i_Ready,
    output logic [127:0] o_Data
);
    localparam int unsigned N_PASS = 16 / BYTES_PER_CYCLE;
    localparam int unsigned CNT_W  = (N_PASS > 1) ? $clog2(N_PASS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0] INV_EXP = 8'd254;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mode;
    logic [127:0]     r_work;
    logic             r_ready;
    logic             r_valid;

    logic [1:0]       w_state;
    logic [CNT_W-1:0] w_cnt;
    logic             w_mode;
    logic [127:0]     w_work;
    logic             w_ready;
    logic             w_valid;
    logic [127:0]     w_lanes;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 = x^-1 in GF(2^8); maps 0 to 0 without a special case
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int i = 0; i < 8; i++) begin
            if (INV_EXP[i]) r = gf_mul(r, sq);
            sq = gf_mul(sq, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x, input logic fwd);
        logic [7:0] t;
        if (fwd) begin
            t = gf_inv(x);
            return t ^ rotl8(t, 1) ^ rotl8(t, 2) ^ rotl8(t, 3) ^ rotl8(t, 4) ^ 8'h63;
        end
        t = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
        return gf_inv(t);
    endfunction

    // Substitute the bytes selected by the current pass; all others pass through
    always_comb begin
        int unsigned idx;
        w_lanes = r_work;
        for (int unsigned l = 0; l < BYTES_PER_CYCLE; l++) begin
            idx = 32'(r_cnt) * BYTES_PER_CYCLE + l;
            w_lanes[8*(15-idx) +: 8] = sbox(r_work[8*(15-idx) +: 8], r_mode);
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_mode  = r_mode;
        w_work  = r_work;
        case (r_state)
            S_IDLE: begin
                if (i_Valid) begin
                    w_work  = i_Data;
                    w_mode  = i_fEncrypt;
                    w_cnt   = '0;
                    w_state = S_BUSY;
                end
            end
            S_BUSY: begin
                w_work = w_lanes;
                if (r_cnt == CNT_W'(N_PASS - 1)) begin
                    w_state = S_DONE;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (i_Ready) w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
        w_ready = (w_state == S_IDLE);
        w_valid = (w_state == S_DONE);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mode  <= 1'b1;
            r_work  <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_mode  <= w_mode;
            r_work  <= w_work;
            r_ready <= w_ready;
            r_valid <= w_valid;
        end
    end

    assign o_Ready = r_ready;
    assign o_Valid = r_valid;
    assign o_Data  = r_work;

endmodule
